// File: rtl/alu_operand_sel.sv
// N-channel operand selector feeding the ALU input register.
// Supports direct or round-robin selection, a one-entry output register and valid/ready on both sides.
module alu_operand_sel #(
  parameter int  WIDTH  = 16,
  parameter int  NUM_CH = 4,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_mode,
  input  logic [SEL_W-1:0]        i_sel,
  input  logic [NUM_CH*WIDTH-1:0] i_in_data,
  input  logic [NUM_CH-1:0]       i_in_valid,
  output logic [NUM_CH-1:0]       o_in_ready,
  output logic [WIDTH-1:0]        o_out_data,
  output logic [SEL_W-1:0]        o_out_ch,
  output logic                    o_out_valid,
  input  logic                    i_out_ready
);

  logic [SEL_W-1:0] r_ptr;
  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_ch;
  logic             r_valid;

  logic             w_gnt_any;
  logic [SEL_W-1:0] w_gnt_idx;
  logic [WIDTH-1:0] w_gnt_data;
  logic [NUM_CH-1:0] w_grant;
  logic             w_can_accept;
  logic             w_xfer;
  logic [SEL_W-1:0] w_ptr_next;

  // Grant selection: direct match on sel, or a two-pass scan (ptr..NUM_CH-1, then 0..ptr-1).
  always_comb begin
    w_gnt_any  = 1'b0;
    w_gnt_idx  = '0;
    w_gnt_data = '0;
    if (!i_mode) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!w_gnt_any && i_in_valid[i] && (i_sel == SEL_W'(i))) begin
          w_gnt_any  = 1'b1;
          w_gnt_idx  = SEL_W'(i);
          w_gnt_data = i_in_data[i*WIDTH +: WIDTH];
        end else begin
          w_gnt_any = w_gnt_any;
        end
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!w_gnt_any && i_in_valid[i] && (SEL_W'(i) >= r_ptr)) begin
          w_gnt_any  = 1'b1;
          w_gnt_idx  = SEL_W'(i);
          w_gnt_data = i_in_data[i*WIDTH +: WIDTH];
        end else begin
          w_gnt_any = w_gnt_any;
        end
      end
      // Nothing at or above ptr: the lowest valid index below ptr wins.
      for (int i = 0; i < NUM_CH; i++) begin
        if (!w_gnt_any && i_in_valid[i]) begin
          w_gnt_any  = 1'b1;
          w_gnt_idx  = SEL_W'(i);
          w_gnt_data = i_in_data[i*WIDTH +: WIDTH];
        end else begin
          w_gnt_any = w_gnt_any;
        end
      end
    end
  end

  // One-hot grant vector and handshake qualifiers.
  always_comb begin
    w_grant = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_grant[i] = w_gnt_any && (w_gnt_idx == SEL_W'(i));
    end
    w_can_accept = !r_valid || i_out_ready;
    w_xfer       = w_gnt_any && w_can_accept;
    if (w_gnt_idx == SEL_W'(NUM_CH - 1)) begin
      w_ptr_next = '0;
    end else begin
      w_ptr_next = w_gnt_idx + SEL_W'(1);
    end
  end

  assign o_in_ready = w_grant & {NUM_CH{w_can_accept & rst_n}};

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ch    <= '0;
      r_ptr   <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_gnt_data;
      r_ch    <= w_gnt_idx;
      if (i_mode) begin
        r_ptr <= w_ptr_next;
      end
    end else if (i_out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_out_data  = r_data;
  assign o_out_ch    = r_ch;
  assign o_out_valid = r_valid;

endmodule

// File: doc/alu_operand_sel.md
# alu_operand_sel

Parametrised N-channel, WIDTH-bit operand selector with a registered output and valid/ready handshakes on every port. It is the next generation of the ALU's fixed 16-bit 2:1 operand mux. It adds three things: any channel count, a round-robin arbitration mode beside direct select, and back-pressure so operand sources and the ALU input stage can stall independently. It sits between the operand sources (register file ports, immediate path, forwarding paths) and the ALU input register.

## Interface
- WIDTH, 16: data width per channel, ≥1.
- NUM_CH, 4: number of input channels, ≥2. Need not be a power of two.
- SEL_W, derived localparam = $clog2(NUM_CH): width of the select and channel-id fields.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  1  0 = direct select by sel, 1 = round-robin among valid channels.
- sel  in  SEL_W  channel to pass in mode 0; ignored in mode 1.
- in_data  in  NUM_CH*WIDTH  flattened inputs; channel i occupies [i*WIDTH +: WIDTH].
- in_valid  in  NUM_CH  per-channel valid.
- in_ready  out  NUM_CH  per-channel ready; combinational; at most one bit high.
- out_data  out  WIDTH  registered selected data.
- out_ch  out  SEL_W  registered index of the channel that supplied out_data.
- out_valid  out  1  output register holds data.
- out_ready  in  1  consumer accepts out_data this cycle.

## Operation
- One-entry output register: out_data, out_ch, out_valid. Internal round-robin pointer ptr (SEL_W bits).
- can_accept = !out_valid | out_ready.
- Grant in mode 0: channel sel is granted if in_valid[sel]=1 and sel < NUM_CH. Otherwise nothing is granted.
- Grant in mode 1: the granted channel is the first i with in_valid[i]=1, scanning ptr, ptr+1, … NUM_CH-1, 0, … ptr-1. Nothing is granted if all in_valid are 0.
- in_ready[i] = grant[i] & can_accept & rst_n. A transfer from channel i happens when in_valid[i] & in_ready[i].
- On an input transfer: out_data ← that channel's data, out_ch ← i, out_valid ← 1.
- On an output-only drain (out_valid & out_ready, no input transfer): out_valid ← 0. out_data and out_ch hold their last value.
- Simultaneous drain and input transfer: the register is reloaded and out_valid stays 1. This gives full throughput.
- ptr update: on an input transfer in mode 1, ptr ← (i+1) mod NUM_CH, wrapping at NUM_CH, not at 2^SEL_W. Mode 0 transfers leave ptr unchanged.
- mode and sel may change any cycle. They affect only the next grant, never a held output.
- Stall: while out_valid=1 and out_ready=0, out_data and out_ch are stable and all in_ready are 0.

## Timing
- Reset values (asynchronous, while rst_n=0): out_valid=0, out_data=0, out_ch=0, ptr=0, all in_ready=0.
- First cycle after reset release: the block can accept (can_accept=1).
- Latency: an input accepted at edge k appears on out_data/out_valid after edge k, i.e. 1 cycle.
- Throughput: one transfer per cycle with out_ready held at 1.
- No combinational path from in_valid to out_valid. in_ready depends combinationally on in_valid (mode 1 scan), mode, sel, out_valid and out_ready.
- Reset asserted mid-stall: held data is discarded and out_valid drops immediately (asynchronously).

## Test plan
- Reset: assert rst_n=0 with all in_valid=1 → out_valid=0, out_data=0, out_ch=0, in_ready=0; after release with mode=0, sel=2, in_data ch2=0x1234 → next cycle out_data=0x1234, out_ch=2, out_valid=1.
- Direct select and invalid sel: NUM_CH=3, mode=0, sel=3, all valid → in_ready=0 forever, out_valid stays 0; then sel=1 → ch1 accepted within 1 cycle.
- Round-robin fairness: mode=1, out_ready=1, all 4 channels valid continuously → out_ch sequence 0,1,2,3,0,1 on consecutive cycles; valid only on ch1 and ch3 → 1,3,1,3.
- Back-pressure: out_valid=1 with out_data=0xBEEF, out_ready=0 for 5 cycles while inputs change → out_data stays 0xBEEF, in_ready=0; drop then raise out_ready → same-cycle drain and reload, no bubble.
- Pointer wrap with NUM_CH=3: mode=1, last grant ch2, only ch0 and ch2 valid → next grant is ch0 (ptr wrapped to 0, not 3).
- Reset mid-operation: assert rst_n=0 while stalled with out_valid=1 → out_valid=0 within the same cycle, ptr back to 0; first round-robin grant after release is the lowest valid index.
